fp_arbiter: RTL

- Round-robin arbiter and sequencer that shares one fp_unit instance between NREQ independent requesters, for example integer pipelines or vector lanes.
- Accepts one operation at a time, drives fp_exe_i with a single-cycle enable pulse, and waits for fp_unit ready.
- Returns result and flags to the originating requester under a valid/ready response handshake.
- A watchdog aborts a hung operation.

---
 rtl/fp_arbiter_pkg.sv | 32 +++
 rtl/fp_arbiter_rr_pick.sv | 38 +++
 rtl/fp_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fp_arbiter_pkg.sv
// fp_arbiter_pkg: shared types for the fp_unit arbiter.
//   fp_exe_in_type     operation bundle driven into fp_unit.fp_exe_i
//   fp_arb_state_type  arbiter sequencer states
//   fp_arb_rsp_type    registered response (result, IEEE flags, abort flag)
package fp_arbiter_pkg;

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [4:0]  op;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic        enable;
  } fp_exe_in_type;

  localparam logic [4:0] FP_OP_FADD = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fp_arb_state_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        err;
  } fp_arb_rsp_type;

endpackage

// File: rtl/fp_arbiter_rr_pick.sv
// fp_rr_pick: combinational round-robin priority picker.
//   req    in   NREQ  request vector
//   ptr    in   PW    highest-priority position this round
//   grant  out  NREQ  one-hot grant (first set bit from ptr upward, wrapping)
//   idx    out  PW    binary index of the grant
//   any    out  1     at least one request present
module fp_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int          j;
    logic [PW-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/fp_arbiter.sv
// fp_arbiter: round-robin arbiter/sequencer sharing one fp_unit among NREQ
// requesters. One operation is outstanding at a time; a watchdog aborts an
// operation whose fp_unit never reports ready.
//   clock, reset   clock / asynchronous active-high reset
//   req_valid      in   per-requester operation valid
//   req_data       in   per-requester operation (enable field ignored)
//   req_ready      out  one-hot accept pulse
//   rsp_valid      out  one-hot response pending
//   rsp_ready      in   per-requester response accept
//   rsp_result/rsp_flags/rsp_err  out  completed response
//   fpu_i          out  to fp_unit.fp_exe_i
//   fpu_result/fpu_flags/fpu_ready  in  from fp_unit.fp_exe_o
//   busy           out  arbiter not idle
module fp_arbiter
  import fp_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  fp_exe_in_type        req_data [NREQ],
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [63:0]          rsp_result,
  output logic [4:0]           rsp_flags,
  output logic                 rsp_err,
  output fp_exe_in_type        fpu_i,
  input  logic [63:0]          fpu_result,
  input  logic [4:0]           fpu_flags,
  input  logic                 fpu_ready,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  fp_arb_state_type state, state_nxt;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  fp_exe_in_type    op_reg;
  fp_arb_rsp_type   rsp_reg;
  logic [CW-1:0]    wdog;
  logic             wdog_expired;

  logic [NREQ-1:0]  pick_grant;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  fp_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign wdog_expired = (wdog == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; fpu_ready is only honoured in WAIT, so a ready level
  // already present during ISSUE cannot complete the operation early.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fpu_ready || wdog_expired) state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation, ownership, watchdog and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_reg  <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      rsp_reg <= '0;
      wdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only the granted slice is sampled.
          if (pick_any) begin
            op_reg <= req_data[pick_idx];
            owner  <= pick_idx;
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          if (fpu_ready) begin
            rsp_reg.result <= fpu_result;
            rsp_reg.flags  <= fpu_flags;
            rsp_reg.err    <= 1'b0;
          end else if (wdog_expired) begin
            rsp_reg.result <= '0;
            rsp_reg.flags  <= '0;
            rsp_reg.err    <= 1'b1;
          end else begin
            // Never reaches past TIMEOUT-1, so it cannot wrap.
            wdog <= wdog + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[owner])
            rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && !reset) req_ready = pick_grant;
    if (state == RESP) rsp_valid[owner] = 1'b1;
    fpu_i        = op_reg;
    fpu_i.enable = (state == ISSUE);
    busy         = (state != IDLE);
    rsp_result   = rsp_reg.result;
    rsp_flags    = rsp_reg.flags;
    rsp_err      = rsp_reg.err;
  end

endmodule
